// File: rtl/coin_start_sequencer.sv
// Arcade coin/start sequencer: turns a player start request into coin pulse(s)
// followed by a start pulse, or passes the raw requests straight through.
module coin_start_sequencer #(
  parameter int COIN_LEN  = 1843200,
  parameter int GAP_LEN   = 1843200,
  parameter int START_LEN = 921600
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic auto_en,
  input  logic start1_req,
  input  logic start2_req,
  input  logic coin_req,
  output logic coin,
  output logic start1,
  output logic start2,
  output logic busy
);

  localparam int MAX_AB  = (COIN_LEN > GAP_LEN) ? COIN_LEN : GAP_LEN;
  localparam int MAX_LEN = (MAX_AB > START_LEN) ? MAX_AB : START_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] COIN_LD  = CNT_W'(COIN_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic SEL_P1 = 1'b0;
  localparam logic SEL_P2 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP1,
    S_COIN2,
    S_GAP2,
    S_START,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              req1_q, req2_q;
  logic              armed_q;
  logic              coin_q, coin_d;
  logic              start1_q, start1_d;
  logic              start2_q, start2_d;
  logic              busy_q, busy_d;
  logic              rise1, rise2;
  logic              expired;

  // armed_q masks the first post-reset cycle so a level held through reset
  // is absorbed into the delay registers instead of reading as an edge.
  assign rise1   = armed_q & start1_req & ~req1_q;
  assign rise2   = armed_q & start2_req & ~req2_q;
  assign expired = (cnt_q == CNT_ZERO);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      sel_q    <= SEL_P1;
      req1_q   <= 1'b0;
      req2_q   <= 1'b0;
      armed_q  <= 1'b0;
      coin_q   <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      req1_q   <= start1_req;
      req2_q   <= start2_req;
      armed_q  <= 1'b1;
      coin_q   <= coin_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (auto_en && (rise1 || rise2)) begin
          state_d = S_COIN;
          cnt_d   = COIN_LD;
          sel_d   = rise1 ? SEL_P1 : SEL_P2;
        end
      end
      S_COIN: begin
        if (expired) begin
          state_d = S_GAP1;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP1: begin
        if (expired) begin
          if (sel_q == SEL_P2) begin
            state_d = S_COIN2;
            cnt_d   = COIN_LD;
          end else begin
            state_d = S_START;
            cnt_d   = START_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_COIN2: begin
        if (expired) begin
          state_d = S_GAP2;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP2: begin
        if (expired) begin
          state_d = S_START;
          cnt_d   = START_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_START: begin
        if (expired) begin
          state_d = S_RELEASE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RELEASE: begin
        // Wait for both buttons up so a held start cannot retrigger.
        if (!start1_req && !start2_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decode the next state so each register lines up with its phase.
  always_comb begin
    coin_d   = 1'b0;
    start1_d = 1'b0;
    start2_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    unique case (state_d)
      S_COIN, S_COIN2: coin_d = 1'b1;
      S_START: begin
        start1_d = (sel_d == SEL_P1);
        start2_d = (sel_d == SEL_P2);
      end
      S_IDLE: begin
        if (!auto_en) begin
          coin_d   = coin_req;
          start1_d = start1_req;
          start2_d = start2_req;
        end
      end
      default: begin
        coin_d = 1'b0;
      end
    endcase
  end

  assign coin   = coin_q;
  assign start1 = start1_q;
  assign start2 = start2_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Scoreboard bench for coin_start_sequencer with short phase lengths 10/5/4.
module tb_coin_start_sequencer;

  localparam int CL = 10;
  localparam int GL = 5;
  localparam int SL = 4;

  logic clk_sys    = 1'b0;
  logic reset_n    = 1'b0;
  logic auto_en    = 1'b1;
  logic start1_req = 1'b0;
  logic start2_req = 1'b0;
  logic coin_req   = 1'b0;
  logic coin, start1, start2, busy;

  coin_start_sequencer #(
    .COIN_LEN (CL),
    .GAP_LEN  (GL),
    .START_LEN(SL)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .auto_en   (auto_en),
    .start1_req(start1_req),
    .start2_req(start2_req),
    .coin_req  (coin_req),
    .coin      (coin),
    .start1    (start1),
    .start2    (start2),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  function automatic void check(string name, int at, logic [3:0] act, logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b (coin,start1,start2,busy)", name, at, act, want);
    end
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input logic ae, input logic c, input logic s1, input logic s2);
    auto_en    = ae;
    coin_req   = c;
    start1_req = s1;
    start2_req = s2;
  endtask

  task automatic expect_next(input string tag, input logic c, input logic s1,
                             input logic s2, input logic b);
    exp_t e;
    e.at  = cyc + 1;
    e.v   = {c, s1, s2, b};
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        mon_e = sb_q.pop_front();
        check(mon_e.tag, mon_e.at, {coin, start1, start2, busy}, mon_e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [16:0] pc, p1, p2;

    drive(1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_state", cyc, {coin, start1, start2, busy}, 4'b0000);
    reset_n = 1'b1;

    for (int r = 0; r < 3; r++) begin
      drive(1'b1, r == 1, 1'b0, 1'b0);
      expect_next("idle_coin_ignored", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end

    for (int r = 0; r < 24; r++) begin
      k = r + 1;
      drive(1'b1, r == 12, r < 5, 1'b0);
      expect_next("seq_p1", k <= 10, (k >= 16) && (k <= 19), 1'b0, k <= 20);
      tick();
    end

    for (int r = 0; r < 38; r++) begin
      k = r + 1;
      drive(1'b1, 1'b0, 1'b0, r < 3);
      expect_next("seq_p2", (k <= 10) || ((k >= 16) && (k <= 25)), 1'b0,
                  (k >= 31) && (k <= 34), k <= 35);
      tick();
    end

    for (int r = 0; r < 24; r++) begin
      k = r + 1;
      drive(1'b1, 1'b0, (r < 4) || (r == 12), (r < 4) || (r == 8) || (r == 9));
      expect_next("both_p1_wins", k <= 10, (k >= 16) && (k <= 19), 1'b0, k <= 20);
      tick();
    end

    pc = 17'b0_1011_0010_1100_1101;
    p1 = 17'b0_0110_1101_0011_0110;
    p2 = 17'b0_1100_0111_1010_0011;
    for (int r = 0; r < 17; r++) begin
      drive(1'b0, pc[r], p1[r], p2[r]);
      expect_next("pass_through", pc[r], p1[r], p2[r], 1'b0);
      tick();
    end

    for (int r = 0; r < 43; r++) begin
      logic c, s1, s2;
      k  = r + 1;
      c  = (r == 27) || (r == 38);
      s1 = (r == 39) || (r == 40);
      s2 = (r < 3);
      drive(r < 12, c, s1, s2);
      if (k <= 35)
        expect_next("auto_off_mid_seq", (k <= 10) || ((k >= 16) && (k <= 25)), 1'b0,
                    (k >= 31) && (k <= 34), 1'b1);
      else
        expect_next("auto_off_resume", c, s1, s2, 1'b0);
      tick();
    end

    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      expect_next("pre_reset_coin", 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    @(negedge clk_sys);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", cyc, {coin, start1, start2, busy}, 4'b0000);
    tick();
    tick();
    check("reset_hold", cyc, {coin, start1, start2, busy}, 4'b0000);
    reset_n = 1'b1;

    for (int r = 0; r < 31; r++) begin
      k = r + 1;
      drive(1'b1, 1'b0, (r < 6) || (r == 8) || (r == 9), 1'b0);
      expect_next("post_reset_held", (k >= 9) && (k <= 18), (k >= 24) && (k <= 27),
                  1'b0, (k >= 9) && (k <= 28));
      tick();
    end

    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
